// File: rtl/sr_pkg.sv
// sr_pkg: shared line-buffer state encoding and width helper
package sr_pkg;
  localparam logic LB_FILL = 1'b0;
  localparam logic LB_STREAM = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/bram_subbank.sv
// bram_subbank: single-port row store with registered read data
module bram_subbank #(
  parameter int DEPTH = 960,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_cs,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_cs && i_we) r_mem[i_addr] <= i_din;
    if (i_cs && i_re) o_dout <= r_mem[i_addr];
  end
endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: rotating-bank line buffer emitting NUM_LINES-tall pixel columns
// LINEBUF_STALL_CNT_EN adds a saturating output-stall counter port stall_cnt.
module line_buffer_ctrl
  import sr_pkg::*;
#(
  parameter int IMG_WIDTH = 960,
  parameter int IMG_HEIGHT = 540,
  parameter int NUM_LINES = 4,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            s_ready,
  output logic                            m_valid,
  output logic [NUM_LINES*DATA_WIDTH-1:0] m_data,
  input  logic                            m_ready,
  output logic                            m_eol,
  output logic                            m_eof
`ifdef LINEBUF_STALL_CNT_EN
  ,
  output logic [31:0]                     stall_cnt
`endif
);
  localparam int LW = clog2(NUM_LINES);
  localparam int RW = clog2(IMG_HEIGHT);
  logic                  r_state;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [RW-1:0]         r_row;
  logic [LW-1:0]         r_wptr;
  logic [LW-1:0]         r_base;
  logic                  r_valid;
  logic                  r_eol;
  logic                  r_eof;
  logic [DATA_WIDTH-1:0] r_cur;
  logic [DATA_WIDTH-1:0] w_dout [NUM_LINES];
  logic                  w_acc;
  logic                  w_stream;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [LW-1:0]         w_wptr_inc;
  assign w_stream   = r_state == LB_STREAM;
  assign s_ready    = !w_stream || !r_valid || m_ready;
  assign w_acc      = s_valid && s_ready;
  assign w_last_col = r_col == ADDR_WIDTH'(IMG_WIDTH - 1);
  assign w_last_row = r_row == RW'(IMG_HEIGHT - 1);
  assign w_wptr_inc = (r_wptr == LW'(NUM_LINES - 1)) ? '0 : r_wptr + LW'(1);
  assign m_valid    = r_valid;
  assign m_eol      = r_eol;
  assign m_eof      = r_eof;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LB_FILL;
      r_col   <= '0;
      r_row   <= '0;
      r_wptr  <= '0;
      r_base  <= '0;
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_cur   <= '0;
    end else begin
      if (w_acc) begin
        r_col <= w_last_col ? '0 : r_col + ADDR_WIDTH'(1);
        if (w_last_col) begin
          r_row  <= w_last_row ? '0 : r_row + RW'(1);
          r_wptr <= w_last_row ? '0 : w_wptr_inc;
          if (w_last_row) r_state <= LB_FILL;
          else if (r_row == RW'(NUM_LINES - 2)) r_state <= LB_STREAM;
        end
      end
      if (w_acc && w_stream) begin
        r_valid <= 1'b1;
        r_cur   <= s_data;
        r_base  <= w_wptr_inc;
        r_eol   <= w_last_col;
        r_eof   <= w_last_col && w_last_row;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  // reads only fire on accept, so a stalled column keeps its bank outputs
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_bank
    bram_subbank #(
      .DEPTH(IMG_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk(clk),
      .i_cs(1'b1),
      .i_we(w_acc && r_wptr == LW'(i)),
      .i_re(w_acc && w_stream && r_wptr != LW'(i)),
      .i_addr(r_col),
      .i_din(s_data),
      .o_dout(w_dout[i])
    );
  end
  always_comb begin
    m_data = '0;
    for (int k = 0; k < NUM_LINES - 1; k++)
      m_data[k*DATA_WIDTH +: DATA_WIDTH] = w_dout[LW'((int'(r_base) + k) % NUM_LINES)];
    m_data[(NUM_LINES-1)*DATA_WIDTH +: DATA_WIDTH] = r_cur;
  end
`ifdef LINEBUF_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (r_valid && !m_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule
